exec_stage: RTL
===============

# exec_stage

Execute-stage controller that sits directly upstream of the `alu` block. It accepts decoded operations from the issue stage over a valid/ready handshake, drives the ALU's `SRC_A`/`SRC_B`/`ALU_CONTROL` inputs, and captures `ALU_OUT` into a one-entry output register for writeback. Scalar MULT can optionally run on an internal iterative shift-add multiplier instead of the ALU's combinational multiplier. All other ops (ADD/SUB/XOR, vector ADDV/SUBV/XORV/SLV/SRV/SCLV/SCRV, NOP) complete through the ALU in one cycle.

## Interface
- `WIDTH`, 32, datapath width; must match the attached `alu`
- `RD_W`, 5, destination-register tag width
- `CLK` in 1: single clock, all state updates on rising edge
- `RESET` in 1: synchronous, active-high; sampled on `CLK` rising edge
- `IN_VALID` in 1: issue stage presents an op
- `IN_READY` out 1: stage accepts op this cycle
- `IN_OP` in 4: ALU control encoding
  - 0000 ADD, 0001 SUB, 0010 MULT, 0011 XOR
  - 0100 ADDV, 0101 SUBV, 0110 XORV, 0111 SLV
  - 1000 SRV, 1001 SCLV, 1010 SCRV, 1111 NOP
- `IN_SRC_A` in WIDTH: operand A
- `IN_SRC_B` in WIDTH: operand B
- `IN_RD` in RD_W: destination tag
- `ALU_SRC_A` out WIDTH: to alu `SRC_A`
- `ALU_SRC_B` out WIDTH: to alu `SRC_B`
- `ALU_CONTROL` out 4: to alu `ALU_CONTROL`
- `ALU_RESULT` in WIDTH: from alu `ALU_OUT`
- `OUT_VALID` out 1: result register holds a result
- `OUT_READY` in 1: writeback consumes result
- `OUT_RESULT` out WIDTH: registered result
- `OUT_RD` out RD_W: registered destination tag
- `OUT_WE` out 1: register-write enable; 0 for NOP and undefined opcodes
- `BUSY` out 1: multiplier iterating

## Operation
- **States.** IDLE and MUL. MUL exists only when `MULT_ITER_EN` is defined.
- **Accept.** `IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY)`. This is a combinational path from `OUT_READY`. An op is accepted when `IN_VALID && IN_READY` at a rising edge.
- **ALU drive in IDLE.** `ALU_SRC_A/ALU_SRC_B/ALU_CONTROL` mirror `IN_SRC_A/IN_SRC_B/IN_OP` combinationally.
- **ALU drive in MUL.** `ALU_CONTROL=4'b1111`, both sources 0.
- **Single-cycle ops.** On accept, the output register loads `ALU_RESULT`, `IN_RD`, and `OUT_WE`, and sets `OUT_VALID=1`.
- **NOP and undefined ops.** Opcodes 1011–1110 are treated as NOP: `ALU_CONTROL` is forced to 1111, `OUT_WE=0`, and `OUT_RESULT` takes the ALU's NOP output. The op still occupies the output slot.
- **Drain.** If `OUT_VALID && OUT_READY` with no accept, `OUT_VALID` clears. If both a drain and an accept happen in the same cycle, the new result replaces the old one and `OUT_VALID` stays 1.
- **MULT with macro.**
  - Accept loads three registers: multiplicand ← A, multiplier ← B, accumulator ← 0; counter ← 0; state goes to MUL.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - On the iteration where counter==WIDTH-1, the final accumulator is written to the output register with `OUT_WE=1`, and state returns to IDLE.
  - Result is the low WIDTH bits of A*B (unsigned; wraps modulo 2^WIDTH).
  - The output register is always empty when MUL completes, because no accept can occur during MUL.
- **Idle.** `BUSY = (state==MUL)`.

## Timing
- **Reset values.** `OUT_VALID=0`, `OUT_RESULT=0`, `OUT_RD=0`, `OUT_WE=0`, `BUSY=0`, state IDLE, counter 0.
- **Reset during MUL.** The multiply is aborted, nothing is written, and `IN_READY` evaluates normally in the next cycle.
- **Non-MULT latency.** 1 cycle: accept at edge N, `OUT_VALID` high after edge N.
- **MULT latency with macro.** WIDTH cycles.
  - Accept at edge N; iterations run at edges N+1..N+WIDTH.
  - `OUT_VALID` goes high after edge N+WIDTH.
  - `IN_READY` stays 0 after edge N through edge N+WIDTH.
- **Throughput.** One op per cycle for single-cycle ops while `OUT_READY=1`.
- **Stability under backpressure.** While `OUT_VALID && !OUT_READY`, the signals `OUT_RESULT/OUT_RD/OUT_WE` are held stable.

## Configuration
- **`MULT_ITER_EN` defined.** MULT (0010) uses the internal iterative multiplier, with WIDTH-cycle latency and `BUSY` behaviour as above. The ALU's multiplier output is never sampled.
- **`MULT_ITER_EN` undefined.**
  - MULT is treated as a single-cycle op and captures `ALU_RESULT`.
  - The MUL state, counter, and shift registers are not generated.
  - `BUSY` is tied to 0.

## Test plan
- **ADD.** ADD, A=4, B=100, RD=3, `OUT_READY=1` → after 1 edge: `OUT_VALID=1`, `OUT_RESULT=104`, `OUT_RD=3`, `OUT_WE=1`.
- **MULT with macro.** MULT, A=4, B=100 → `BUSY=1` and `IN_READY=0` for 32 cycles; then `OUT_RESULT=400`, `OUT_WE=1`. Repeat with A=B=32'hFFFF_FFFF → result 32'h0000_0001.
- **Backpressure.** SUB 4−100 with `OUT_READY=0` → `OUT_RESULT=32'hFFFF_FFA0` held. `IN_READY=0` while a second op is pending. Raising `OUT_READY` accepts the second op in the same cycle.
- **Back-to-back.** SCLV A=254 with B=0..7 issued back-to-back, `OUT_READY=1` → 8 consecutive results, one per cycle, each equal to the ALU output for that B.
- **NOP and undefined.** NOP and opcode 1100 → `ALU_CONTROL=1111`, `OUT_VALID=1`, `OUT_WE=0`.
- **Reset mid-MULT.** Assert `RESET` at cycle 10 of a MULT → `OUT_VALID=0`, `BUSY=0` next cycle. A following ADD completes normally.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage -- execute-stage controller sitting in front of the `alu` block.
//
// Accepts decoded ops over a valid/ready handshake, drives the ALU operand
// and control inputs, and captures the ALU result into a one-entry output
// register for writeback.
//
// Optional feature macro: MULT_ITER_EN
//   defined   : scalar MULT (0010) runs on an internal shift-add multiplier
//               taking WIDTH cycles; BUSY is high while it iterates.
//   undefined : MULT completes in one cycle through the ALU; BUSY is tied 0.
//
// Ports
//   CLK, RESET               clock, synchronous active-high reset
//   IN_VALID/IN_READY        issue handshake
//   IN_OP, IN_SRC_A/B, IN_RD operation, operands, destination tag
//   ALU_SRC_A/B, ALU_CONTROL to the alu
//   ALU_RESULT               from the alu ALU_OUT
//   OUT_VALID/OUT_READY      writeback handshake
//   OUT_RESULT, OUT_RD       registered result and destination tag
//   OUT_WE                   register-write enable (0 for NOP/undefined ops)
//   BUSY                     iterative multiplier running
module exec_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       IN_OP,
    input  logic [WIDTH-1:0] IN_SRC_A,
    input  logic [WIDTH-1:0] IN_SRC_B,
    input  logic [RD_W-1:0]  IN_RD,
    output logic [WIDTH-1:0] ALU_SRC_A,
    output logic [WIDTH-1:0] ALU_SRC_B,
    output logic [3:0]       ALU_CONTROL,
    input  logic [WIDTH-1:0] ALU_RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RESULT,
    output logic [RD_W-1:0]  OUT_RD,
    output logic             OUT_WE,
    output logic             BUSY
);

    localparam logic [3:0] OP_NOP      = 4'b1111;
    localparam logic [3:0] OP_LAST_DEF = 4'b1010;   // SCRV, highest defined op

    // Opcodes 1011..1110 behave exactly like NOP.
    logic       op_defined;
    logic [3:0] in_ctrl;
    assign op_defined = (IN_OP <= OP_LAST_DEF);
    assign in_ctrl    = op_defined ? IN_OP : OP_NOP;

    logic             out_valid_reg,  out_valid_next;
    logic [WIDTH-1:0] out_result_reg, out_result_next;
    logic [RD_W-1:0]  out_rd_reg,     out_rd_next;
    logic             out_we_reg,     out_we_next;

    logic             idle;
    logic             accept;
    logic             load_alu;     // accepted op completes through the ALU
    logic             mul_done;     // final multiplier iteration this cycle
    logic [WIDTH-1:0] mul_result;
    logic [RD_W-1:0]  mul_rd;

`ifdef MULT_ITER_EN
    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state_reg, state_next;

    logic [WIDTH-1:0] mcand_reg,  mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [RD_W-1:0]  mul_rd_reg, mul_rd_next;
    logic             mul_start;

    assign mul_start = accept && (IN_OP == OP_MULT);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (mul_start)         state_next = S_MUL;
            S_MUL:   if (cnt_reg == CNT_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        idle     = (state_reg == S_IDLE);
        BUSY     = (state_reg == S_MUL);
        mul_done = (state_reg == S_MUL) && (cnt_reg == CNT_LAST);
    end

    // Shift-add datapath. The completing iteration forwards its accumulate
    // result straight into the output register.
    assign acc_step   = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign mul_result = acc_step;
    assign mul_rd     = mul_rd_reg;
    assign load_alu   = accept && !mul_start;

    always_comb begin
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        mul_rd_next = mul_rd_reg;
        if (mul_start) begin
            mcand_next  = IN_SRC_A;
            mplier_next = IN_SRC_B;
            acc_next    = '0;
            cnt_next    = '0;
            mul_rd_next = IN_RD;
        end else if (state_reg == S_MUL) begin
            acc_next    = acc_step;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            mul_rd_reg <= '0;
        end else begin
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            mul_rd_reg <= mul_rd_next;
        end
    end
`else
    assign idle       = 1'b1;
    assign BUSY       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_rd     = '0;
    assign load_alu   = accept;
`endif

    // Handshake: accept only when idle and the output slot is free or
    // being drained this same cycle.
    assign IN_READY = idle && (!out_valid_reg || OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    // While the multiplier runs the ALU is parked on NOP with zero operands.
    assign ALU_SRC_A   = idle ? IN_SRC_A : '0;
    assign ALU_SRC_B   = idle ? IN_SRC_B : '0;
    assign ALU_CONTROL = idle ? in_ctrl  : OP_NOP;

    // Output register: load wins over drain, so a same-cycle drain+accept
    // simply replaces the entry.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_result_next = out_result_reg;
        out_rd_next     = out_rd_reg;
        out_we_next     = out_we_reg;
        if (load_alu) begin
            out_valid_next  = 1'b1;
            out_result_next = ALU_RESULT;
            out_rd_next     = IN_RD;
            out_we_next     = op_defined;
        end else if (mul_done) begin
            out_valid_next  = 1'b1;
            out_result_next = mul_result;
            out_rd_next     = mul_rd;
            out_we_next     = 1'b1;
        end else if (out_valid_reg && OUT_READY) begin
            out_valid_next  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_rd_reg     <= '0;
            out_we_reg     <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_result_reg <= out_result_next;
            out_rd_reg     <= out_rd_next;
            out_we_reg     <= out_we_next;
        end
    end

    assign OUT_VALID  = out_valid_reg;
    assign OUT_RESULT = out_result_reg;
    assign OUT_RD     = out_rd_reg;
    assign OUT_WE     = out_we_reg;

endmodule
